// File: rtl/accumulator_core.sv
// accumulator_core
// ----------------
// Multi-cycle accumulator processor. Each instruction is fetched from a
// combinational program memory, then executed against the accumulator (A),
// a small register file (RF) and a carry flag (C). Data memory is reached
// through a registered request that is held until the memory answers.
//
// Ports
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   imem_addr     : program memory address, always equal to the PC
//   imem_data     : instruction at imem_addr, valid in the same cycle
//   dmem_req      : data memory request (registered)
//   dmem_we       : 1 = write, 0 = read; meaningful while dmem_req = 1
//   dmem_addr     : data memory address
//   dmem_wdata    : write data (accumulator value at request time)
//   dmem_rdata    : read data, sampled when dmem_ready = 1 in MEM
//   dmem_ready    : completes the outstanding request; ignored outside MEM
//   acc_out       : accumulator
//   carry_out     : carry flag
//   halted        : core is in HALT (left only by reset)
//
// Handshake: once dmem_req rises (on the edge leaving EXEC) the request,
// direction, address and write data are held stable every cycle until the
// cycle in which dmem_ready = 1; that edge completes the access and drops
// dmem_req. Exactly one request is issued per memory instruction.
//
// Instruction word: op = [15:12], mode = [11:10] (00 RF, 01 imm, 10 mem,
// 11 reserved), r = low bits, imm = [7:0], maddr = [MEM_ADDR_WIDTH-1:0],
// target = [PC_WIDTH-1:0].
//
// Parameter legality: DATA_WIDTH >= 8, RF_DEPTH a power of two in 2..16,
// PC_WIDTH <= 10, MEM_ADDR_WIDTH <= 10.

module accumulator_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_DEPTH       = 4,
    parameter int PC_WIDTH       = 5,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic [15:0]               imem_data,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    input  logic                      dmem_ready,
    output logic [DATA_WIDTH-1:0]     acc_out,
    output logic                      carry_out,
    output logic                      halted
);

    localparam int RF_AW = $clog2(RF_DEPTH);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_STM = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] MODE_RF  = 2'b00;
    localparam logic [1:0] MODE_IMM = 2'b01;
    localparam logic [1:0] MODE_MEM = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // FSM state is kept as a named enum so checkers can bind to 'state'.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Architectural state
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] acc;
    logic                  carry;
    logic [15:0]           ir;
    logic [DATA_WIDTH-1:0] rf [RF_DEPTH];

    // Instruction fields
    logic [3:0]                op;
    logic [1:0]                mode;
    logic [RF_AW-1:0]          r_idx;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [MEM_ADDR_WIDTH-1:0] maddr;
    logic [PC_WIDTH-1:0]       target;
    logic [PC_WIDTH-1:0]       pc_inc;

    // Decode results
    logic uses_src;      // opcode consumes a source operand
    logic src_exec;      // source opcode with a usable (non-reserved) mode
    logic is_mem_op;     // instruction needs a data memory access
    logic branch_taken;

    // Control strobes from the FSM output process
    logic ir_load;
    logic exec_done;
    logic mem_start;
    logic mem_done;

    // ALU
    logic [DATA_WIDTH-1:0] src_val;
    logic [DATA_WIDTH-1:0] alu_acc;
    logic                  alu_carry;
    logic [DATA_WIDTH:0]   sum_ext;

    assign op      = ir[15:12];
    assign mode    = ir[11:10];
    assign r_idx   = ir[RF_AW-1:0];
    assign imm_ext = DATA_WIDTH'(ir[7:0]);
    assign maddr   = ir[MEM_ADDR_WIDTH-1:0];
    assign target  = ir[PC_WIDTH-1:0];
    assign pc_inc  = pc + PC_WIDTH'(1);

    always_comb begin
        uses_src = 1'b0;
        case (op)
            OP_LD, OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: uses_src = 1'b1;
            default: uses_src = 1'b0;
        endcase
    end

    // Reserved mode turns a source-using opcode into a NOP.
    assign src_exec  = uses_src && (mode != MODE_RSV);
    assign is_mem_op = (uses_src && (mode == MODE_MEM)) || (op == OP_STM);

    always_comb begin
        branch_taken = 1'b0;
        case (op)
            OP_JMP:  branch_taken = 1'b1;
            OP_JZ:   branch_taken = (acc == '0);
            OP_JC:   branch_taken = carry;
            default: branch_taken = 1'b0;
        endcase
    end

    // Memory-mode operands only matter in MEM, where dmem_rdata is the value
    // being returned on the completing edge.
    always_comb begin
        src_val = '0;
        case (mode)
            MODE_RF:  src_val = rf[r_idx];
            MODE_IMM: src_val = imm_ext;
            MODE_MEM: src_val = dmem_rdata;
            default:  src_val = '0;
        endcase
    end

    always_comb begin
        alu_acc   = acc;
        alu_carry = carry;
        sum_ext   = '0;
        case (op)
            OP_LD: alu_acc = src_val;
            OP_ADD: begin
                sum_ext   = {1'b0, acc} + {1'b0, src_val};
                alu_acc   = sum_ext[DATA_WIDTH-1:0];
                alu_carry = sum_ext[DATA_WIDTH];
            end
            OP_ADC: begin
                sum_ext   = {1'b0, acc} + {1'b0, src_val} + {{DATA_WIDTH{1'b0}}, carry};
                alu_acc   = sum_ext[DATA_WIDTH-1:0];
                alu_carry = sum_ext[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_acc   = acc - src_val;
                alu_carry = (acc < src_val);   // borrow
            end
            OP_AND: alu_acc = acc & src_val;
            OP_OR:  alu_acc = acc | src_val;
            OP_XOR: alu_acc = acc ^ src_val;
            default: begin
                alu_acc   = acc;
                alu_carry = carry;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_HLT) begin
                    state_nxt = S_HALT;
                end else if (is_mem_op) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEM:   state_nxt = dmem_ready ? S_FETCH : S_MEM;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // FSM: output logic (datapath strobes and the halted flag)
    always_comb begin
        ir_load   = 1'b0;
        exec_done = 1'b0;
        mem_start = 1'b0;
        mem_done  = 1'b0;
        halted    = 1'b0;
        unique case (state)
            S_FETCH: ir_load = 1'b1;
            S_EXEC: begin
                if (is_mem_op) begin
                    mem_start = 1'b1;
                end else if (op != OP_HLT) begin
                    exec_done = 1'b1;
                end
            end
            S_MEM:   mem_done = dmem_ready;
            S_HALT:  halted   = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            ir         <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ir_load) begin
                ir <= imem_data;
            end

            // Request fields are loaded once here and left untouched until
            // the completing edge, which keeps them stable through MEM.
            if (mem_start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= (op == OP_STM);
                dmem_addr  <= maddr;
                dmem_wdata <= acc;
            end

            if (exec_done) begin
                if (src_exec) begin
                    acc   <= alu_acc;
                    carry <= alu_carry;
                end
                if (op == OP_ST) begin
                    rf[r_idx] <= acc;
                end
                pc <= branch_taken ? target : pc_inc;
            end

            if (mem_done) begin
                dmem_req <= 1'b0;
                if (uses_src) begin
                    acc   <= alu_acc;
                    carry <= alu_carry;
                end
                pc <= pc_inc;
            end
        end
    end

    assign imem_addr = pc;
    assign acc_out   = acc;
    assign carry_out = carry;

endmodule

// File: doc/accumulator_core.md
# accumulator_core

Parametrised multi-cycle accumulator processor core: fetches 16-bit instructions from an external combinational program memory, executes them against an accumulator, a register file of RF_DEPTH entries and a carry flag, and accesses data memory through a req/ready handshake. It adds conditional branches, a carry-chained add, a halt state and wait-state-tolerant memory access. It is the single-instance core instantiated by the system top level between program memory and data memory.

## Interface
- DATA_WIDTH, 8: accumulator, register file and data memory word width; must be ≥ 8.
- RF_DEPTH, 4: register file entries; power of two, 2..16.
- PC_WIDTH, 5: program counter width; must be ≤ 10.
- MEM_ADDR_WIDTH, 10: data memory address width; must be ≤ 10.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  PC_WIDTH  program memory address; equals the PC.
- imem_data  input  16  instruction at imem_addr, valid in the same cycle.
- dmem_req  output  1  data memory request, registered.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req = 1.
- dmem_addr  output  MEM_ADDR_WIDTH  data memory address.
- dmem_wdata  output  DATA_WIDTH  write data; the accumulator value.
- dmem_rdata  input  DATA_WIDTH  read data; sampled when dmem_ready = 1.
- dmem_ready  input  1  completes the outstanding request.
- acc_out  output  DATA_WIDTH  accumulator value.
- carry_out  output  1  carry flag.
- halted  output  1  core is in HALT.

## Operation
- Instruction fields: op = [15:12], mode = [11:10] (00 RF, 01 immediate, 10 memory, 11 reserved), r = low log2(RF_DEPTH) bits, imm = [7:0] zero-extended, maddr = [MEM_ADDR_WIDTH-1:0], target = [PC_WIDTH-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LD: A ← src.
  - 2 ST: RF[r] ← A.
  - 3 STM: mem[maddr] ← A.
  - 4 ADD: {C,A} ← A+src.
  - 5 ADC: {C,A} ← A+src+C.
  - 6 SUB: A ← A−src; C ← (A < src).
  - 7 AND, 8 OR, 9 XOR: A ← A op src; C unchanged.
  - A JMP: PC ← target.
  - B JZ: PC ← target if A == 0.
  - C JC: PC ← target if C == 1.
  - D, E: NOP.
  - F HLT.
- src is RF[r], imm, or mem[maddr], selected by mode. Mode 11 on any src-using opcode executes as NOP.
- Arithmetic is modulo 2^DATA_WIDTH. Carry is bit DATA_WIDTH of the unsigned sum.
- PC increments modulo 2^PC_WIDTH, so 2^PC_WIDTH−1 wraps to 0. Untaken branches increment the PC.
- FSM states:
  - FETCH: latch IR ← imem_data; go to EXEC.
  - EXEC: memory ops (mode 10 source, or STM) set dmem_req = 1, dmem_we, dmem_addr and dmem_wdata, then go to MEM. HLT goes to HALT. All other ops complete: update A/RF/C/PC, go to FETCH.
  - MEM: wait for dmem_ready. On ready, clear dmem_req, complete the op with the captured dmem_rdata, advance PC, go to FETCH.
  - HALT: terminal; only reset leaves it. PC, A, C and RF are frozen; halted = 1.
- dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable from MEM entry until the ready cycle. Exactly one request per memory instruction.
- Reset values: PC 0, A 0, C 0, all RF entries 0, IR 0, state FETCH, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, halted 0.

## Timing
- Non-memory instruction: 2 cycles (FETCH, EXEC).
- Memory instruction: 2 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the one where dmem_ready = 1.
- dmem_req rises on the clock edge leaving EXEC. A dmem_ready already high in the first MEM cycle completes the access with N = 1.
- dmem_ready outside MEM is ignored.
- Results appear on acc_out, carry_out and imem_addr on the edge that completes the instruction. halted rises on the edge leaving EXEC of HLT.
- Reset asserted mid-access drops dmem_req asynchronously; no completion or writeback occurs.
- ST followed by LD of the same register returns the stored value; no hazard exists in a multi-cycle core.

## Test plan
- Reset: program LDI 0x05; ADD imm 0xFF; JC 0. Required response: A = 0x04, C = 1 after the ADD, PC = 0 after the JC, each instruction 2 cycles.
- Carry chain: A = 0xFF; ADD imm 0x01 gives A = 0x00, C = 1. ADC imm 0x00 then gives A = 0x01, C = 0. SUB imm 0x02 from 0x01 gives A = 0xFF, C = 1.
- Register file: LDI 0x3C; ST r3; LDI 0; LD RF r3. Required response: A = 0x3C. AND imm 0x0F gives A = 0x0C with C unchanged.
- Memory wait states: STM 0x2A5 with dmem_ready delayed 3 cycles. Required response: dmem_req held high 3 cycles with addr 0x2A5, we = 1 and wdata = A, then deasserts. A following LD mem 0x2A5 with ready in the first MEM cycle takes 3 cycles total.
- Branch/wrap: at PC 31 a NOP wraps PC to 0. JZ with A = 0 is taken; JZ with A ≠ 0 falls through to PC + 1.
- Halt/reset: HLT sets halted = 1, and PC/A stay frozen over 10 cycles while dmem_ready is toggled. Reset asserted mid-MEM clears dmem_req within the same cycle and returns all outputs to their reset values.
